shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Multi-cycle shift sequencer for the core ALU: accepts one shift request (SLL/SRL/SRA),
//  iterates the operand by 4 or 1 bit per cycle, and returns the result via valid/ready.
//  Sits between the decode/execute FSM and the register writeback.
//  Replaces the single-cycle barrel shift when area matters.
// PARAMETERS
//  TWO_STAGE_SHIFT  1  1: step 4 bits while remaining count >= 4, then 1-bit steps; 0: 1-bit steps only
//  BARREL_SHIFTER   0  1: full shift in one SHIFT cycle (overrides TWO_STAGE_SHIFT)
// PORTS
//  clk        in   1   clock, rising edge
//  resetn     in   1   asynchronous reset, active low
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid && in_ready
//  in_op      in   2   {arith,right}: 00 SLL, 01 SRL, 11 SRA, 10 decodes as SLL
//  in_data    in   32  operand (reg_op1)
//  in_shamt   in   5   shift amount (reg_op2[4:0])
//  flush      in   1   abort current operation (trap/branch kill)
//  out_valid  out  1   result valid
//  out_ready  in   1   result consumed when out_valid && out_ready
//  out_data   out  32  shift result
//  busy       out  1   high in SHIFT or DONE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; out_data=0; count=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. On accept: latch data/op, count=in_shamt. If shamt==0, go to DONE; otherwise go to SHIFT.
//   SHIFT: one step per cycle. Step is 4 if TWO_STAGE_SHIFT && count>=4, else 1.
//    Step applied: SLL: data<<step; SRL: data>>step; SRA: sign-filled using latched data[31].
//    count -= step. When new count==0, go to DONE.
//    With BARREL_SHIFTER: whole shamt applied in one cycle, then DONE.
//   DONE: out_valid=1, out_data stable. On out_ready, go to IDLE (in_ready high the next cycle).
//  Latency (accept edge to out_valid high), in cycles:
//   shamt==0: 1.
//   BARREL: 2.
//   TWO_STAGE: 1 + floor(N/4) + N%4.
//   1-bit steps only: 1 + N.
//  in_ready low outside IDLE; requests presented then are not accepted (no queue).
//  No back-to-back accept: DONE->IDLE costs one cycle.
//  out_valid, once high, stays high with stable out_data until out_ready or flush.
//  flush: from any state, next state=IDLE, out_valid=0, count=0.
//   flush && in_valid in IDLE: flush wins, no accept.
//   flush && out_ready in DONE: result counts as dropped; consumer must ignore it.
//  resetn deassertion mid-operation: FSM and outputs go to reset values immediately; no partial result is emitted.
//  All arithmetic is 32-bit; sign bit for SRA comes from the latched operand, never from live inputs.
// STRUCTURE
//  Package shift_pkg: op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11;
//   state typedef {ST_IDLE, ST_SHIFT, ST_DONE}.
//  Sub-module shift_step: combinational; inputs data, op, step amount[4:0];
//   output shifted data. One instance, used for the 1-bit, 4-bit and full (barrel) step.
//  Top: FSM, count register, data register, handshake logic.
// TESTING
//  1. SLL, data=32'h0000_0001, shamt=5, TWO_STAGE=1 -> out_data=32'h0000_0020; out_valid 3 cycles after accept (4+1).
//  2. SRA, data=32'h8000_0000, shamt=31 -> out_data=32'hFFFF_FFFF; SRL same input -> 32'h0000_0001; latency 11 (7x4+3).
//  3. shamt=0, data=32'hDEAD_BEEF, any op -> out_data=32'hDEAD_BEEF; out_valid 1 cycle after accept.
//  4. out_ready held low 5 cycles in DONE -> out_valid and out_data stable; in_ready=0 throughout;
//     new in_valid not accepted until 1 cycle after handshake.
//  5. flush asserted mid-SHIFT (shamt=17) -> next cycle IDLE, out_valid never rises;
//     following request (SLL 32'h1 by 1) returns 32'h2.
//  6. resetn pulsed low mid-SHIFT -> outputs at reset values asynchronously; BARREL_SHIFTER=1 run gives latency 2 for shamt=13.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    // Shift op encodings, {arith, right}; 2'b10 is not listed and decodes as SLL
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle between execute FSM, shifter and writeback.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; flush aborts.
interface shift_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    // Requester / consumer side
    modport master (
        output in_valid, in_op, in_data, in_shamt, flush, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Shifter side
    modport slave (
        input  in_valid, in_op, in_data, in_shamt, flush, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_seq_ctrl_step.sv
// One shift step of amt_i bits (1, 4 or the full barrel amount).
// Latency: combinational.
// Backpressure: none.
module shift_step
    import shift_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  op_i,
    input  logic [4:0]  amt_i,
    output logic [31:0] res_o
);

    // Sign fill for SRA comes from data_i[31], which the caller feeds from the latched operand
    always_comb begin
        res_o = data_i << amt_i;
        case (op_i)
            SH_SLL:  res_o = data_i << amt_i;
            SH_SRL:  res_o = data_i >> amt_i;
            SH_SRA:  res_o = 32'($signed(data_i) >>> amt_i);
            default: res_o = data_i << amt_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: 4-bit then 1-bit steps, or one barrel step.
// Latency: shamt==0 -> 1; barrel -> 2; two-stage -> 1+N/4+N%4; 1-bit only -> 1+N.
// Backpressure: one request in flight; in_ready only in IDLE; result held until out_ready or flush.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter bit TWO_STAGE_SHIFT = 1'b1,
    parameter bit BARREL_SHIFTER  = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    shift_seq_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    logic [31:0] data_q;
    logic [1:0]  op_q;
    logic [4:0]  count_q;
    logic [4:0]  step_amt;
    logic [4:0]  count_nxt;
    logic [31:0] shifted;
    logic        accept;

    // Flush beats a same-cycle request so a killed slot never starts work
    assign accept = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;

    // Step size: whole remaining count in barrel mode, else 4 while possible, then 1
    always_comb begin
        step_amt = 5'd1;
        if (BARREL_SHIFTER)
            step_amt = count_q;
        else if (TWO_STAGE_SHIFT && (count_q >= 5'd4))
            step_amt = 5'd4;
        count_nxt = count_q - step_amt;
    end

    shift_step u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .amt_i  (step_amt),
        .res_o  (shifted)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: IDLE -> SHIFT (or DONE for zero shift) -> DONE -> IDLE; flush returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (bus.in_shamt == 5'd0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (count_nxt == 5'd0) state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    // Outputs decoded from state; result register drives out_data directly so it is stable in DONE
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.busy      = (state_q != ST_IDLE);
        bus.out_data  = data_q;
    end

    // Operand/count registers: latch on accept, advance one step per SHIFT cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= 32'd0;
            op_q    <= SH_SLL;
            count_q <= 5'd0;
        end else if (bus.flush) begin
            count_q <= 5'd0;
        end else if (accept) begin
            data_q  <= bus.in_data;
            op_q    <= bus.in_op;
            count_q <= bus.in_shamt;
        end else if (state_q == ST_SHIFT) begin
            data_q  <= shifted;
            count_q <= count_nxt;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    shift_seq_ctrl_if bus_a ();
    shift_seq_ctrl_if bus_b ();

    shift_seq_ctrl #(.TWO_STAGE_SHIFT(1'b1), .BARREL_SHIFTER(1'b0)) u_dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a));
    shift_seq_ctrl #(.TWO_STAGE_SHIFT(1'b1), .BARREL_SHIFTER(1'b1)) u_dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b));

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                             input logic [4:0] sh);
        logic signed [31:0] s;
        s = d;
        case (op)
            2'b01:   return d >> sh;
            2'b11:   return 32'(s >>> sh);
            default: return d << sh;
        endcase
    endfunction

    function automatic int lat_two(input logic [4:0] sh);
        if (sh == 5'd0) return 1;
        return 1 + int'(sh) / 4 + int'(sh) % 4;
    endfunction

    function automatic int lat_bar(input logic [4:0] sh);
        return (sh == 5'd0) ? 1 : 2;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus_a.in_valid = 0; bus_a.in_op = 0; bus_a.in_data = 0; bus_a.in_shamt = 0;
        bus_a.flush = 0; bus_a.out_ready = 0;
        bus_b.in_valid = 0; bus_b.in_op = 0; bus_b.in_data = 0; bus_b.in_shamt = 0;
        bus_b.flush = 0; bus_b.out_ready = 0;
    endtask

    function automatic logic obs_vld(input bit use_b);
        return use_b ? bus_b.out_valid : bus_a.out_valid;
    endfunction

    // Issue one request, measure latency, then consume and score the result
    task automatic run_op(input bit use_b, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input int exp_lat, input string nm);
        int lat;
        logic [31:0] got, exp;
        lat = 0;
        while (!(use_b ? bus_b.in_ready : bus_a.in_ready) && lat < 64) begin tick(); lat++; end
        checks++;
        if (!(use_b ? bus_b.in_ready : bus_a.in_ready)) begin
            errors++; $display("FAIL %s in_ready timeout got=0 exp=1", nm);
        end
        bus_a.in_op = op; bus_a.in_data = d; bus_a.in_shamt = sh;
        bus_b.in_op = op; bus_b.in_data = d; bus_b.in_shamt = sh;
        if (use_b) bus_b.in_valid = 1; else bus_a.in_valid = 1;
        exp_q.push_back(ref_shift(op, d, sh));
        tick();
        bus_a.in_valid = 0; bus_b.in_valid = 0;
        lat = 1;
        while (!obs_vld(use_b) && lat < 64) begin tick(); lat++; end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat);
        end
        if (use_b) bus_b.out_ready = 1; else bus_a.out_ready = 1;
        got = use_b ? bus_b.out_data : bus_a.out_data;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL %s out_data got=%h exp=%h", nm, got, exp);
        end
        tick();
        bus_a.out_ready = 0; bus_b.out_ready = 0;
        checks++;
        if ((use_b ? bus_b.out_valid : bus_a.out_valid) !== 1'b0) begin
            errors++; $display("FAIL %s out_valid after handshake got=1 exp=0", nm);
        end
    endtask

    task automatic test_reset;
        drive_idle();
        resetn = 0;
        #12;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", bus_a.in_ready); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", bus_a.out_valid); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus_a.busy); end
        checks++; if (bus_a.out_data !== 32'h0) begin errors++; $display("FAIL reset out_data got=%h exp=0", bus_a.out_data); end
        checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL reset b in_ready got=%b exp=1", bus_b.in_ready); end
        @(negedge clk);
        resetn = 1;
        tick();
    endtask

    task automatic test_basic;
        run_op(0, SH_SLL, 32'h0000_0001, 5'd5, 3, "sll5");
        run_op(0, SH_SRA, 32'h8000_0000, 5'd31, 11, "sra31");
        run_op(0, SH_SRL, 32'h8000_0000, 5'd31, 11, "srl31");
        run_op(0, SH_SLL, 32'hDEAD_BEEF, 5'd0, 1, "zero_sll");
        run_op(0, SH_SRA, 32'hDEAD_BEEF, 5'd0, 1, "zero_sra");
        run_op(0, 2'b10, 32'h0000_0003, 5'd6, lat_two(5'd6), "op10_sll");
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [31:0] d;
        logic [4:0] sh;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3)); d = $urandom; sh = 5'($urandom_range(0, 31));
            run_op(0, op, d, sh, lat_two(sh), "rand_two");
        end
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3)); d = $urandom; sh = 5'($urandom_range(0, 31));
            run_op(1, op, d, sh, lat_bar(sh), "rand_bar");
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] exp;
        bus_a.in_op = SH_SRL; bus_a.in_data = 32'hF000_000F; bus_a.in_shamt = 5'd4;
        bus_a.in_valid = 1;
        exp_q.push_back(ref_shift(SH_SRL, 32'hF000_000F, 5'd4));
        tick();
        bus_a.in_valid = 0;
        lat = 1;
        while (!bus_a.out_valid && lat < 64) begin tick(); lat++; end
        checks++; if (lat != 2) begin errors++; $display("FAIL bp latency got=%0d exp=2", lat); end
        // Next request waits while the result is held
        bus_a.in_op = SH_SLL; bus_a.in_data = 32'h0000_0003; bus_a.in_shamt = 5'd2;
        bus_a.in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== exp_q[0] || bus_a.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                         i, bus_a.out_valid, bus_a.out_data, bus_a.in_ready, exp_q[0]);
            end
        end
        bus_a.out_ready = 1;
        exp = exp_q.pop_front();
        checks++; if (bus_a.out_data !== exp) begin errors++; $display("FAIL bp out_data got=%h exp=%h", bus_a.out_data, exp); end
        tick();
        bus_a.out_ready = 0;
        checks++;
        if (bus_a.in_ready !== 1'b1 || bus_a.busy !== 1'b0) begin
            errors++; $display("FAIL bp after handshake got rdy=%b busy=%b exp rdy=1 busy=0", bus_a.in_ready, bus_a.busy);
        end
        exp_q.push_back(ref_shift(SH_SLL, 32'h0000_0003, 5'd2));
        tick();
        bus_a.in_valid = 0;
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL bp second accept busy got=%b exp=1", bus_a.busy); end
        lat = 1;
        while (!bus_a.out_valid && lat < 64) begin tick(); lat++; end
        checks++; if (lat != lat_two(5'd2)) begin errors++; $display("FAIL bp2 latency got=%0d exp=%0d", lat, lat_two(5'd2)); end
        bus_a.out_ready = 1;
        exp = exp_q.pop_front();
        checks++; if (bus_a.out_data !== exp) begin errors++; $display("FAIL bp2 out_data got=%h exp=%h", bus_a.out_data, exp); end
        tick();
        bus_a.out_ready = 0;
    endtask

    task automatic test_flush;
        bit seen;
        bus_a.in_op = SH_SLL; bus_a.in_data = 32'h0000_0001; bus_a.in_shamt = 5'd17;
        bus_a.in_valid = 1;
        tick();
        bus_a.in_valid = 0;
        tick(); tick();
        bus_a.flush = 1;
        tick();
        bus_a.flush = 0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_shift got busy=%b rdy=%b v=%b exp 0/1/0", bus_a.busy, bus_a.in_ready, bus_a.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (bus_a.out_valid) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_shift out_valid rose got=1 exp=0"); end
        // Flush and request together in IDLE: request is dropped
        bus_a.in_valid = 1; bus_a.flush = 1;
        tick();
        bus_a.in_valid = 0; bus_a.flush = 0;
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy got=%b exp=0", bus_a.busy); end
        // Flush in DONE drops the result even with out_ready
        bus_a.in_shamt = 5'd0; bus_a.in_valid = 1;
        tick();
        bus_a.in_valid = 0;
        bus_a.flush = 1; bus_a.out_ready = 1;
        tick();
        bus_a.flush = 0; bus_a.out_ready = 0;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++; $display("FAIL flush_done got v=%b busy=%b exp 0/0", bus_a.out_valid, bus_a.busy);
        end
        run_op(0, SH_SLL, 32'h0000_0001, 5'd1, 2, "after_flush");
    endtask

    task automatic test_async_reset;
        bit seen;
        bus_a.in_op = SH_SRA; bus_a.in_data = 32'h8000_0000; bus_a.in_shamt = 5'd31;
        bus_a.in_valid = 1;
        tick();
        bus_a.in_valid = 0;
        tick(); tick();
        #2;
        resetn = 0;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b busy=%b rdy=%b d=%h exp 0/0/1/0",
                     bus_a.out_valid, bus_a.busy, bus_a.in_ready, bus_a.out_data);
        end
        @(negedge clk);
        resetn = 1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (bus_a.out_valid) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL async_reset partial result got=1 exp=0"); end
        run_op(1, SH_SRA, 32'hF000_0000, 5'd13, 2, "barrel13");
        run_op(1, SH_SLL, 32'h0000_00FF, 5'd0, 1, "barrel0");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
